// File: rtl/mul_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Holds the FSM encoding, default sizes and the round-robin pick.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_REQ = 4;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit,
  // then add rr_ptr back modulo n.
  function automatic logic [2:0] rr_pick(
    input logic [7:0]  valid,
    input logic [2:0]  ptr,
    input int unsigned n
  );
    logic [7:0]  mask;
    logic [7:0]  v;
    logic [15:0] wide;
    logic [7:0]  rot;
    logic [2:0]  idx;
    mask = 8'((16'd1 << n) - 16'd1);
    v    = valid & mask;
    wide = {8'h00, v};
    rot  = 8'((wide >> ptr) | (wide << (n - int'(ptr)))) & mask;
    idx  = '0;
    for (int i = 7; i >= 0; i--)
      if (rot[i]) idx = 3'(i);
    return 3'((int'(idx) + int'(ptr)) % n);
  endfunction

endpackage

// File: rtl/mul_array_comb.sv
// Combinational WIDTH x WIDTH unsigned multiplier.
// Sums shifted partial products gated by each multiplier bit.
module mul_array_comb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < int'(WIDTH); i++)
      if (b[i]) p = p + (a_ext << i);
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one multiplier among NUM_REQ requesters.
// Capture, multiply, then hold the tagged result until consumed.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic [IDW-1:0]           resp_id
);

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     id_q;
  logic [IDW-1:0]     grant;
  logic [IDW-1:0]     next_ptr;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;
  logic               take;

  assign grant = IDW'(rr_pick(8'(req_valid), 3'(rr_ptr), NUM_REQ));
  assign take  = !rst && (state == IDLE) && (|req_valid);

  assign next_ptr = (grant == IDW'(NUM_REQ - 1)) ? '0
                                                 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant] = 1'b1;
  end

  mul_array_comb #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      resp_valid   <= 1'b0;
      resp_product <= '0;
      resp_id      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            op_a   <= req_a[grant*WIDTH +: WIDTH];
            op_b   <= req_b[grant*WIDTH +: WIDTH];
            id_q   <= grant;
            rr_ptr <= next_ptr;
            state  <= MUL;
          end
        end
        MUL: begin
          resp_product <= prod;
          resp_id      <= id_q;
          resp_valid   <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
